// File: rtl/mux_nto1_scan.sv
// N:1 registered mux: MANUAL (external sel) or SCAN (round-robin pointer with dwell count); valid/ready output.
// Optional feature macro MUX_PARITY_EN adds out_par (even parity of the captured sample).
module mux_nto1_scan #(
  parameter int WIDTH = 8,
  parameter int CH    = 4,
  parameter int SELW  = 2,
  parameter int DWELL = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [CH*WIDTH-1:0]   in,
  input  logic [SELW-1:0]       sel,
  input  logic                  mode,
  input  logic                  en,
  output logic [WIDTH-1:0]      out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [SELW-1:0]       cur_sel,
`ifdef MUX_PARITY_EN
  output logic                  out_par,
`endif
  output logic                  sel_err
);

  localparam int DCW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [SELW:0]   CH_W       = (SELW+1)'(CH);
  localparam logic [SELW-1:0] LAST_CH    = SELW'(CH - 1);
  localparam logic [DCW-1:0]  LAST_DWELL = DCW'(DWELL - 1);

  typedef enum logic {ST_MANUAL = 1'b0, ST_SCAN = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [SELW-1:0]   ptr_q, ptr_d;
  logic [DCW-1:0]    dwell_q, dwell_d;
  logic [WIDTH-1:0]  out_q, out_d;
  logic              valid_q, valid_d;
  logic [SELW-1:0]   cur_q, cur_d;
  logic              err_q, err_d;
  logic              load;
  logic [SELW-1:0]   chan;
  logic [WIDTH-1:0]  mux_dat;

  // The load always uses the registered state, so a mode change lands one cycle later.
  always_comb begin
    state_d = mode ? ST_SCAN : ST_MANUAL;
    ptr_d   = ptr_q;
    dwell_d = dwell_q;
    out_d   = out_q;
    valid_d = valid_q;
    cur_d   = cur_q;
    err_d   = err_q;
    load    = en && (!valid_q || out_ready);
    chan    = (state_q == ST_SCAN) ? ptr_q : sel;
    mux_dat = '0;
    for (int k = 0; k < CH; k++) begin
      if (chan == SELW'(k)) mux_dat = in[k*WIDTH +: WIDTH];
    end

    if (load) begin
      out_d   = mux_dat;
      valid_d = 1'b1;
      cur_d   = chan;
      err_d   = ({1'b0, chan} >= CH_W);
      if (state_q == ST_SCAN) begin
        if (dwell_q == LAST_DWELL) begin
          dwell_d = '0;
          ptr_d   = (ptr_q == LAST_CH) ? '0 : ptr_q + 1'b1;
        end else begin
          dwell_d = dwell_q + 1'b1;
        end
      end
    end else if (!en && out_ready && valid_q) begin
      valid_d = 1'b0;
    end

    if (state_q == ST_MANUAL && mode) begin
      ptr_d   = '0;
      dwell_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_MANUAL;
      ptr_q   <= '0;
      dwell_q <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      cur_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      dwell_q <= dwell_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      cur_q   <= cur_d;
      err_q   <= err_d;
    end
  end

`ifdef MUX_PARITY_EN
  logic par_q, par_d;

  always_comb begin
    par_d = par_q;
    if (load) par_d = ^mux_dat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) par_q <= 1'b0;
    else        par_q <= par_d;
  end

  assign out_par = par_q;
`endif

  assign out       = out_q;
  assign out_valid = valid_q;
  assign cur_sel   = cur_q;
  assign sel_err   = err_q;

endmodule

// File: tb/tb_mux_nto1_scan.sv
// Bench for mux_nto1_scan at CH=3, DWELL=2: directed cases plus randomized traffic against a sample-count model.
module tb_mux_nto1_scan;
  localparam int W     = 8;
  localparam int CH    = 3;
  localparam int SELW  = 2;
  localparam int DWELL = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [CH*W-1:0] in_d;
  logic [SELW-1:0] sel;
  logic            mode, en, out_ready;
  logic [W-1:0]    out;
  logic            out_valid, sel_err;
  logic [SELW-1:0] cur_sel;
`ifdef MUX_PARITY_EN
  logic            out_par;
`endif

  int checks   = 0;
  int failures = 0;

  // Model: SCAN channel is derived from the number of samples accepted since entering SCAN.
  logic [W-1:0]    m_out;
  logic            m_vld, m_err, m_par, m_state;
  logic [SELW-1:0] m_cur;
  int              m_cnt;

  always #5 clk = ~clk;

  mux_nto1_scan #(.WIDTH(W), .CH(CH), .SELW(SELW), .DWELL(DWELL)) dut (
    .clk(clk), .rst_n(rst_n), .in(in_d), .sel(sel), .mode(mode), .en(en),
    .out(out), .out_valid(out_valid), .out_ready(out_ready), .cur_sel(cur_sel),
`ifdef MUX_PARITY_EN
    .out_par(out_par),
`endif
    .sel_err(sel_err)
  );

  task automatic model_reset();
    m_out = '0; m_vld = 1'b0; m_err = 1'b0; m_par = 1'b0;
    m_cur = '0; m_state = 1'b0; m_cnt = 0;
  endtask

  task automatic tick();
    int ch;
    if (en && (!m_vld || out_ready)) begin
      if (m_state) begin
        ch    = (m_cnt / DWELL) % CH;
        m_cnt = m_cnt + 1;
        m_err = 1'b0;
        m_out = in_d[ch*W +: W];
      end else begin
        ch    = int'(sel);
        m_err = (ch >= CH);
        m_out = m_err ? '0 : in_d[ch*W +: W];
      end
      m_cur = ch[SELW-1:0];
      m_vld = 1'b1;
      m_par = ^m_out;
    end else if (!en && out_ready && m_vld) begin
      m_vld = 1'b0;
    end
    if (!m_state && mode) m_cnt = 0;
    m_state = mode;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_d = '0; sel = '0; mode = 1'b0; en = 1'b0; out_ready = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({out, out_valid, cur_sel, sel_err} !== '0) begin
      failures++;
      $display("FAIL reset: out=%h v=%b cur=%0d err=%b, required all 0", out, out_valid, cur_sel, sel_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_manual();
    in_d = {8'h33, 8'h22, 8'h11}; sel = 2'd2; mode = 1'b0; en = 1'b1; out_ready = 1'b1;
    tick();
    checks++;
    if ({out, out_valid, cur_sel, sel_err} !== {8'h33, 1'b1, 2'd2, 1'b0}) begin
      failures++;
      $display("FAIL manual_sel2: out=%h v=%b cur=%0d err=%b, required 33 1 2 0", out, out_valid, cur_sel, sel_err);
    end
    sel = 2'd3;
    tick();
    checks++;
    if ({out, out_valid, cur_sel, sel_err} !== {8'h00, 1'b1, 2'd3, 1'b1}) begin
      failures++;
      $display("FAIL manual_oob: out=%h v=%b cur=%0d err=%b, required 00 1 3 1", out, out_valid, cur_sel, sel_err);
    end
    sel = 2'd1;
    tick();
    checks++;
    if ({out, cur_sel, sel_err} !== {8'h22, 2'd1, 1'b0}) begin
      failures++;
      $display("FAIL manual_recover: out=%h cur=%0d err=%b, required 22 1 0", out, cur_sel, sel_err);
    end
    en = 1'b0;
    tick();
    checks++;
    if ({out, out_valid, cur_sel} !== {8'h22, 1'b0, 2'd1}) begin
      failures++;
      $display("FAIL manual_drain: out=%h v=%b cur=%0d, required 22 0 1", out, out_valid, cur_sel);
    end
  endtask

  task automatic test_scan();
    logic [SELW-1:0] exp_seq [8] = '{0, 0, 1, 1, 2, 2, 0, 0};
    mode = 1'b1; en = 1'b0; sel = 2'd3;
    tick();
    en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (cur_sel !== exp_seq[i] || out !== in_d[exp_seq[i]*W +: W] || sel_err !== 1'b0) begin
        failures++;
        $display("FAIL scan_seq[%0d]: cur=%0d out=%h err=%b, required cur=%0d out=%h err=0",
                 i, cur_sel, out, sel_err, exp_seq[i], in_d[exp_seq[i]*W +: W]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0]    held_out;
    logic [SELW-1:0] held_cur;
    tick();
    held_out = out; held_cur = cur_sel;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_d = {W'($urandom), W'($urandom), W'($urandom)};
      tick();
      checks++;
      if (out !== held_out || cur_sel !== held_cur || out_valid !== 1'b1) begin
        failures++;
        $display("FAIL stall[%0d]: out=%h cur=%0d v=%b, required %h %0d 1", i, out, cur_sel, out_valid, held_out, held_cur);
      end
    end
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if ({out, out_valid, cur_sel, sel_err} !== {m_out, m_vld, m_cur, m_err}) begin
        failures++;
        $display("FAIL resume[%0d]: out=%h v=%b cur=%0d err=%b, required %h %b %0d %b",
                 i, out, out_valid, cur_sel, sel_err, m_out, m_vld, m_cur, m_err);
      end
    end
  endtask

  task automatic test_async_reset();
    mode = 1'b1; en = 1'b1; out_ready = 1'b1;
    in_d = {8'h5a, 8'ha5, 8'h3c};
    tick();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({out, out_valid, cur_sel, sel_err} !== '0) begin
      failures++;
      $display("FAIL async_reset: out=%h v=%b cur=%0d err=%b, required all 0", out, out_valid, cur_sel, sel_err);
    end
    #1 rst_n = 1'b1;
    model_reset();
    en = 1'b0;
    tick();
    en = 1'b1;
    tick();
    checks++;
    if (cur_sel !== 2'd0 || out !== 8'h3c || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL scan_restart: cur=%0d out=%h v=%b, required 0 3c 1", cur_sel, out, out_valid);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      in_d      = {W'($urandom), W'($urandom), W'($urandom)};
      sel       = SELW'($urandom_range(0, 3));
      en        = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 19) == 0) mode = ~mode;
      tick();
      checks++;
      if ({out, out_valid, cur_sel, sel_err} !== {m_out, m_vld, m_cur, m_err}) begin
        failures++;
        $display("FAIL random[%0d]: out=%h v=%b cur=%0d err=%b, required %h %b %0d %b",
                 i, out, out_valid, cur_sel, sel_err, m_out, m_vld, m_cur, m_err);
      end
`ifdef MUX_PARITY_EN
      checks++;
      if (out_par !== m_par) begin
        failures++;
        $display("FAIL random_par[%0d]: out_par=%b, required %b", i, out_par, m_par);
      end
`endif
    end
  endtask

`ifdef MUX_PARITY_EN
  task automatic test_parity();
    mode = 1'b0; en = 1'b0; out_ready = 1'b1;
    tick();
    sel = 2'd0; en = 1'b1;
    in_d = {8'h00, 8'h00, 8'h07};
    tick();
    checks++;
    if (out !== 8'h07 || out_par !== 1'b1) begin
      failures++;
      $display("FAIL parity_07: out=%h par=%b, required 07 1", out, out_par);
    end
    in_d = {8'h00, 8'h00, 8'h03};
    tick();
    checks++;
    if (out !== 8'h03 || out_par !== 1'b0) begin
      failures++;
      $display("FAIL parity_03: out=%h par=%b, required 03 0", out, out_par);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_manual();
    test_scan();
    test_backpressure();
    test_async_reset();
`ifdef MUX_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
